paddle_key_decoder: RTL
=======================

Name: paddle_key_decoder

Overview:
- Converts the PS/2 scan-code byte stream from the keyboard receiver into the held-key levels `Left`, `Right` and `Turbo`.
- Those levels feed the paddle motion block.
- Tracks make/break and E0-extended prefixes per key.
- Resolves Left+Right conflicts as last-pressed-wins, so the paddle never sees both asserted.

Parameters:
- LEFT_CODE, 8'h6B, scan code of the left key (E0-extended, arrow-left)
- RIGHT_CODE, 8'h74, scan code of the right key (E0-extended, arrow-right)
- TURBO_CODE, 8'h29, scan code of the turbo key (non-extended, space)
- TIMEOUT_CYCLES, 50_000_000, idle cycles before forced release (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- byte_valid  in  1  one-cycle strobe: byte_data holds a new scan-code byte
- byte_data  in  8  received scan-code byte
- Left  out  1  left key effectively held (registered)
- Right  out  1  right key effectively held (registered)
- Turbo  out  1  turbo key held (registered)
- key_event  out  1  one-cycle pulse when any of Left/Right/Turbo changes value

Behaviour:
- Reset (async, active-high):
  - state=IDLE; held flags left_h, right_h, turbo_h = 0; last_dir = 0.
  - Left = Right = Turbo = key_event = 0.
- FSM advances only on cycles with byte_valid=1; with byte_valid=0, state and held flags are unchanged.
- FSM states and transitions:
  - IDLE: E0 -> EXT; F0 -> BRK; TURBO_CODE -> turbo_h=1; any other byte is ignored, stay IDLE.
  - EXT: F0 -> EXT_BRK; LEFT_CODE -> left_h=1, last_dir=0; RIGHT_CODE -> right_h=1, last_dir=1; any other byte -> IDLE.
  - BRK: TURBO_CODE -> turbo_h=0; any byte -> IDLE.
  - EXT_BRK: LEFT_CODE -> left_h=0; RIGHT_CODE -> right_h=0; any byte -> IDLE.
- Non-extended LEFT_CODE/RIGHT_CODE (keypad 4/6) are ignored. Extended TURBO_CODE is ignored.
- Repeated make codes (typematic) re-assert held flags. last_dir updates on every make.
- Status bytes in any state:
  - AA, EE, FA, FC, FE -> IDLE, held flags unchanged.
  - 00 or FF (receiver overrun) -> IDLE and all held flags and last_dir cleared.
  - E0 received in EXT or EXT_BRK -> stay/go EXT (prefix restarts).
  - F0 received in BRK or EXT_BRK -> stay in the same state.
- Output resolution (combinational from held flags, then registered):
  - Lnext = left_h & ~(right_h & last_dir)
  - Rnext = right_h & ~(left_h & ~last_dir)
  - Tnext = turbo_h
  - Left and Right are never both 1.
- Latency: outputs update on the clock edge after the byte_valid cycle carrying the final byte of a sequence. The held flag and the registered output therefore lag byte_valid by 1 and 2 edges respectively.
- key_event = 1 for exactly the cycle in which any output register value differs from its previous value.
- Reset asserted mid-sequence (e.g. after E0) discards the partial sequence. The next byte is decoded from IDLE.
- A byte_valid coincident with reset deassertion is ignored.

Optional Feature:
- Macro: PADDLE_KEY_TIMEOUT_EN.
- Defined:
  - A 32-bit idle counter counts clk cycles, reset to 0 on every byte_valid and on reset.
  - When it reaches TIMEOUT_CYCLES-1 with any held flag set: all held flags clear, state -> IDLE, and key_event pulses if any output falls.
  - The counter saturates until the next byte_valid.
- Not defined: no counter; held flags persist indefinitely until a break code, overrun byte, or reset.

Decomposition:
- Shared package paddle_kbd_pkg holds:
  - FSM state enum kbd_state_t {IDLE, EXT, BRK, EXT_BRK}
  - constants KBD_EXT=8'hE0 and KBD_BRK=8'hF0
  - status-byte constants (AA, EE, FA, FC, FE, 00, FF)
  - default key-code constants
- One natural sub-module: kbd_idle_timer (the optional timeout counter), instantiated only under PADDLE_KEY_TIMEOUT_EN.

Test Plan:
1. Bytes E0,6B -> Left=1 two edges after the 6B strobe, key_event one pulse. Then E0,F0,6B -> Left=0 with one key_event pulse.
2. E0,6B then E0,74 -> Left=0, Right=1 (last pressed wins). Then E0,F0,74 -> Right=0, Left=1 (left still held).
3. Byte 29 -> Turbo=1. E0,29 -> no change. F0,29 -> Turbo=0. Keypad 6B without E0 -> Left stays 0.
4. Overrun: E0,74 then FF -> Right=0, state IDLE. Next bytes E0,6B -> Left=1 (no stale prefix).
5. Reset mid-sequence: E0, assert reset 3 cycles, release, send 6B -> all outputs 0, no key_event. Then E0,6B -> Left=1.
6. With PADDLE_KEY_TIMEOUT_EN and TIMEOUT_CYCLES=100: E0,74 then idle 100 cycles -> Right falls at cycle 100, key_event=1. Without the macro, Right stays 1 for 1000 cycles.

Source files
------------

// File: rtl/paddle_kbd_pkg.sv
// Shared types and byte constants for the PS/2 paddle key decoder.
// Holds the decoder FSM state enum, prefix/status byte codes and default key codes.
package paddle_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_t;

  localparam logic [7:0] KBD_EXT      = 8'hE0;
  localparam logic [7:0] KBD_BRK      = 8'hF0;

  localparam logic [7:0] KBD_BAT_OK   = 8'hAA;
  localparam logic [7:0] KBD_ECHO     = 8'hEE;
  localparam logic [7:0] KBD_ACK      = 8'hFA;
  localparam logic [7:0] KBD_BAT_FAIL = 8'hFC;
  localparam logic [7:0] KBD_RESEND   = 8'hFE;
  localparam logic [7:0] KBD_OVR_LO   = 8'h00;
  localparam logic [7:0] KBD_OVR_HI   = 8'hFF;

  localparam logic [7:0] DEF_LEFT_CODE  = 8'h6B;
  localparam logic [7:0] DEF_RIGHT_CODE = 8'h74;
  localparam logic [7:0] DEF_TURBO_CODE = 8'h29;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 50_000_000;

  // Keyboard housekeeping bytes: abort any partial sequence, keep held keys.
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == KBD_BAT_OK) || (b == KBD_ECHO) || (b == KBD_ACK) ||
           (b == KBD_BAT_FAIL) || (b == KBD_RESEND);
  endfunction

  // Receiver overrun markers: the stream is unreliable, drop every held key.
  function automatic logic is_overrun_byte(input logic [7:0] b);
    return (b == KBD_OVR_LO) || (b == KBD_OVR_HI);
  endfunction

endpackage

// File: rtl/paddle_key_decoder_if.sv
// Byte-stream input and held-key level outputs of the paddle key decoder.
// byte_valid is a one-cycle strobe with no ready: the decoder consumes every strobed byte.
interface paddle_key_decoder_if;
  import paddle_kbd_pkg::*;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       Left;
  logic       Right;
  logic       Turbo;
  logic       key_event;
  kbd_state_t dbg_state;

  modport master (
    output byte_valid, byte_data,
    input  Left, Right, Turbo, key_event, dbg_state
  );

  modport slave (
    input  byte_valid, byte_data,
    output Left, Right, Turbo, key_event, dbg_state
  );

endinterface

// File: rtl/kbd_idle_timer.sv
// Idle counter for the key decoder's forced-release timeout.
// Restarts on every byte strobe and saturates at TIMEOUT_CYCLES-1 until the next one.
module kbd_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_byte_valid,
  output logic o_expired
);

  localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_byte_valid) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_expired = (r_cnt == LIMIT) && !i_byte_valid;

endmodule

// File: rtl/paddle_key_decoder.sv
// PS/2 scan-code decoder producing held Left/Right/Turbo levels for the paddle.
// Optional forced release after an idle period is enabled by PADDLE_KEY_TIMEOUT_EN.
module paddle_key_decoder
  import paddle_kbd_pkg::*;
#(
  parameter logic [7:0]  LEFT_CODE      = DEF_LEFT_CODE,
  parameter logic [7:0]  RIGHT_CODE     = DEF_RIGHT_CODE,
  parameter logic [7:0]  TURBO_CODE     = DEF_TURBO_CODE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                 clk,
  input logic                 reset,
  paddle_key_decoder_if.slave kbd
);

  kbd_state_t r_state, w_state_nxt;
  logic       r_left_h, r_right_h, r_turbo_h, r_last_dir;
  logic       w_left_h_nxt, w_right_h_nxt, w_turbo_h_nxt, w_last_dir_nxt;
  logic       r_armed;
  logic       r_left, r_right, r_turbo, r_event;
  logic       w_accept;
  logic       w_l_res, w_r_res;
  logic [7:0] w_b;

  // The first edge after reset release is skipped so a strobe racing the release is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_armed <= 1'b0;
    else       r_armed <= 1'b1;
  end

  assign w_accept = kbd.byte_valid & r_armed;
  assign w_b      = kbd.byte_data;

`ifdef PADDLE_KEY_TIMEOUT_EN
  logic w_expired;

  kbd_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk         (clk),
    .rst         (reset),
    .i_byte_valid(kbd.byte_valid),
    .o_expired   (w_expired)
  );
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_left_h   <= 1'b0;
      r_right_h  <= 1'b0;
      r_turbo_h  <= 1'b0;
      r_last_dir <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_left_h   <= w_left_h_nxt;
      r_right_h  <= w_right_h_nxt;
      r_turbo_h  <= w_turbo_h_nxt;
      r_last_dir <= w_last_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_left_h_nxt   = r_left_h;
    w_right_h_nxt  = r_right_h;
    w_turbo_h_nxt  = r_turbo_h;
    w_last_dir_nxt = r_last_dir;

    if (w_accept) begin
      if (is_overrun_byte(w_b)) begin
        w_state_nxt    = IDLE;
        w_left_h_nxt   = 1'b0;
        w_right_h_nxt  = 1'b0;
        w_turbo_h_nxt  = 1'b0;
        w_last_dir_nxt = 1'b0;
      end else if (is_status_byte(w_b)) begin
        w_state_nxt = IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_b == KBD_EXT)         w_state_nxt   = EXT;
            else if (w_b == KBD_BRK)    w_state_nxt   = BRK;
            else if (w_b == TURBO_CODE) w_turbo_h_nxt = 1'b1;
          end
          EXT: begin
            w_state_nxt = IDLE;
            if (w_b == KBD_EXT) begin
              w_state_nxt = EXT;
            end else if (w_b == KBD_BRK) begin
              w_state_nxt = EXT_BRK;
            end else if (w_b == LEFT_CODE) begin
              w_left_h_nxt   = 1'b1;
              w_last_dir_nxt = 1'b0;
            end else if (w_b == RIGHT_CODE) begin
              w_right_h_nxt  = 1'b1;
              w_last_dir_nxt = 1'b1;
            end
          end
          BRK: begin
            w_state_nxt = IDLE;
            if (w_b == KBD_BRK)         w_state_nxt   = BRK;
            else if (w_b == TURBO_CODE) w_turbo_h_nxt = 1'b0;
          end
          EXT_BRK: begin
            w_state_nxt = IDLE;
            if (w_b == KBD_EXT)         w_state_nxt   = EXT;
            else if (w_b == KBD_BRK)    w_state_nxt   = EXT_BRK;
            else if (w_b == LEFT_CODE)  w_left_h_nxt  = 1'b0;
            else if (w_b == RIGHT_CODE) w_right_h_nxt = 1'b0;
          end
          default: w_state_nxt = IDLE;
        endcase
      end
    end
`ifdef PADDLE_KEY_TIMEOUT_EN
    else if (w_expired && (r_left_h | r_right_h | r_turbo_h)) begin
      w_state_nxt   = IDLE;
      w_left_h_nxt  = 1'b0;
      w_right_h_nxt = 1'b0;
      w_turbo_h_nxt = 1'b0;
    end
`endif
  end

  // last_dir = 1 means Right was the most recent make: it wins when both are held.
  assign w_l_res = r_left_h  & ~(r_right_h & r_last_dir);
  assign w_r_res = r_right_h & ~(r_left_h  & ~r_last_dir);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_turbo <= 1'b0;
      r_event <= 1'b0;
    end else begin
      r_left  <= w_l_res;
      r_right <= w_r_res;
      r_turbo <= r_turbo_h;
      r_event <= (w_l_res != r_left) | (w_r_res != r_right) | (r_turbo_h != r_turbo);
    end
  end

  assign kbd.Left      = r_left;
  assign kbd.Right     = r_right;
  assign kbd.Turbo     = r_turbo;
  assign kbd.key_event = r_event;
  assign kbd.dbg_state = r_state;

endmodule
